// File: rtl/gf_mul_arbiter_if.sv
// Bundle between the field-arithmetic clients, the arbiter and the shared GF(2^257) multiplier.
// The slave modport is the arbiter's view; master is the environment's view.
interface gf_mul_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 257,
    parameter int unsigned IDW  = 2
);
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] op_a;
    logic [NREQ*DW-1:0] op_b;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    done;
    logic [DW-1:0]      res;
    logic               busy;
    logic [IDW-1:0]     owner;
    logic               m_start;
    logic [DW-1:0]      m_a;
    logic [DW-1:0]      m_b;
    logic [DW-1:0]      m_res;
    logic               m_finish;

    modport slave (
        input  req, op_a, op_b, m_res, m_finish,
        output gnt, done, res, busy, owner, m_start, m_a, m_b
    );

    modport master (
        output req, op_a, op_b, m_res, m_finish,
        input  gnt, done, res, busy, owner, m_start, m_a, m_b
    );
endinterface

// File: rtl/gf_mul_arbiter.sv
// Round-robin arbiter sharing one serial GF(2^257) multiplier among NREQ requesters.
// Grants one requester, pulses m_start, waits for m_finish and returns the product with done.
module gf_mul_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 257,
    parameter int unsigned IDW  = 2
) (
    input logic             clk,
    input logic             rst,
    gf_mul_arbiter_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StStart, StWait, StResp} state_e;

    state_e          state_q;
    logic [NREQ-1:0] gnt_q;
    logic [NREQ-1:0] done_q;
    logic [DW-1:0]   res_q;
    logic [DW-1:0]   m_a_q;
    logic [DW-1:0]   m_b_q;
    logic [IDW-1:0]  owner_q;
    logic [IDW-1:0]  ptr_q;
    logic            m_start_q;

    logic            win_vld;
    logic [IDW-1:0]  win_idx;
    logic [IDW-1:0]  cand;
    logic [DW-1:0]   win_a;
    logic [DW-1:0]   win_b;

    function automatic logic [NREQ-1:0] onehot(input logic [IDW-1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Search starts one past the last winner, so the requester just served ranks last.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = IDW'((32'(ptr_q) + k) % NREQ);
            if (!win_vld && bus.req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        win_a = '0;
        win_b = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win_idx == IDW'(i)) begin
                win_a = bus.op_a[i*DW +: DW];
                win_b = bus.op_b[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            gnt_q     <= '0;
            done_q    <= '0;
            res_q     <= '0;
            m_a_q     <= '0;
            m_b_q     <= '0;
            owner_q   <= '0;
            ptr_q     <= IDW'(NREQ - 1);
            m_start_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (win_vld) begin
                        m_a_q     <= win_a;
                        m_b_q     <= win_b;
                        owner_q   <= win_idx;
                        ptr_q     <= win_idx;
                        m_start_q <= 1'b1;
                        gnt_q     <= onehot(win_idx);
                        state_q   <= StStart;
                    end
                end
                StStart: begin
                    m_start_q <= 1'b0;
                    gnt_q     <= '0;
                    state_q   <= StWait;
                end
                // m_finish seen during StStart belongs to a stale run and is ignored.
                StWait: begin
                    if (bus.m_finish) begin
                        res_q   <= bus.m_res;
                        done_q  <= onehot(owner_q);
                        state_q <= StResp;
                    end
                end
                StResp: begin
                    done_q  <= '0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.done    = done_q;
    assign bus.res     = res_q;
    assign bus.busy    = (state_q != StIdle);
    assign bus.owner   = owner_q;
    assign bus.m_start = m_start_q;
    assign bus.m_a     = m_a_q;
    assign bus.m_b     = m_b_q;

endmodule
